// File: rtl/uart_channel_link.sv
// 16-bit word UART channel: TX sends a word as two 8E1 frames (low byte first),
// RX reassembles two frames into a word with parity and framing checks.
module uart_channel_link #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  baud_select,
  input  logic [15:0] data_in,
  input  logic        transfer_data,
  input  logic        RX_EN,
  input  logic        RxD,
  output logic        TxD,
  output logic        tx_busy,
  output logic [15:0] data_out,
  output logic        rx_valid,
  output logic        rx_error
);

  localparam int unsigned DW = 16;
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);

  function automatic int unsigned div_for(input int unsigned baud);
    return (CLK_FREQ_HZ + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
  endfunction

  localparam logic [DW-1:0] DIV_LAST_0 = DW'(div_for(300) - 1);
  localparam logic [DW-1:0] DIV_LAST_1 = DW'(div_for(1200) - 1);
  localparam logic [DW-1:0] DIV_LAST_2 = DW'(div_for(4800) - 1);
  localparam logic [DW-1:0] DIV_LAST_3 = DW'(div_for(9600) - 1);
  localparam logic [DW-1:0] DIV_LAST_4 = DW'(div_for(19200) - 1);
  localparam logic [DW-1:0] DIV_LAST_5 = DW'(div_for(38400) - 1);
  localparam logic [DW-1:0] DIV_LAST_6 = DW'(div_for(57600) - 1);
  localparam logic [DW-1:0] DIV_LAST_7 = DW'(div_for(115200) - 1);

  logic [DW-1:0] div_last;

  always_comb begin
    case (baud_select)
      3'd0:    div_last = DIV_LAST_0;
      3'd1:    div_last = DIV_LAST_1;
      3'd2:    div_last = DIV_LAST_2;
      3'd3:    div_last = DIV_LAST_3;
      3'd4:    div_last = DIV_LAST_4;
      3'd5:    div_last = DIV_LAST_5;
      3'd6:    div_last = DIV_LAST_6;
      default: div_last = DIV_LAST_7;
    endcase
  end

  // ---------------------------------------------------------------- transmit
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t     tx_state, tx_state_n;
  logic [DW-1:0] tx_div, tx_div_n;
  logic [TW-1:0] tx_tick, tx_tick_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic          tx_byte, tx_byte_n;
  logic [15:0]   tx_word, tx_word_n;
  logic          txd_n, tx_busy_n;
  logic          trig_q1, trig_q2, trig_rise;
  logic          tx_tick_en, tx_bit_done;
  logic [7:0]    tx_cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_q1  <= 1'b0;
      trig_q2  <= 1'b0;
      tx_state <= TX_IDLE;
      tx_div   <= '0;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_byte  <= 1'b0;
      tx_word  <= '0;
      TxD      <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      trig_q1  <= transfer_data;
      trig_q2  <= trig_q1;
      tx_state <= tx_state_n;
      tx_div   <= tx_div_n;
      tx_tick  <= tx_tick_n;
      tx_bit   <= tx_bit_n;
      tx_byte  <= tx_byte_n;
      tx_word  <= tx_word_n;
      TxD      <= txd_n;
      tx_busy  <= tx_busy_n;
    end
  end

  always_comb begin
    trig_rise   = trig_q1 & ~trig_q2;
    tx_tick_en  = (tx_div == div_last);
    tx_bit_done = tx_tick_en && (tx_tick == TICK_LAST);
    tx_state_n  = tx_state;
    tx_div_n    = tx_tick_en ? '0 : tx_div + 1'b1;
    tx_tick_n   = tx_tick_en ? tx_tick + 1'b1 : tx_tick;
    tx_bit_n    = tx_bit;
    tx_byte_n   = tx_byte;
    tx_word_n   = tx_word;
    tx_busy_n   = tx_busy;
    if (tx_bit_done) tx_tick_n = '0;
    case (tx_state)
      TX_IDLE: begin
        tx_div_n  = '0;
        tx_tick_n = '0;
        if (trig_rise) begin
          tx_state_n = TX_START;
          tx_word_n  = data_in;
          tx_byte_n  = 1'b0;
          tx_busy_n  = 1'b1;
        end
      end
      TX_START: if (tx_bit_done) begin
        tx_state_n = TX_DATA;
        tx_bit_n   = '0;
      end
      TX_DATA: if (tx_bit_done) begin
        if (tx_bit == 3'd7) tx_state_n = TX_PARITY;
        else                tx_bit_n   = tx_bit + 1'b1;
      end
      TX_PARITY: if (tx_bit_done) tx_state_n = TX_STOP;
      TX_STOP: if (tx_bit_done) begin
        if (!tx_byte) begin
          tx_state_n = TX_START;
          tx_byte_n  = 1'b1;
        end else begin
          tx_state_n = TX_IDLE;
          tx_busy_n  = 1'b0;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    // TxD is registered from the next-state view so the line changes with the state
    tx_cur = tx_byte_n ? tx_word_n[15:8] : tx_word_n[7:0];
    case (tx_state_n)
      TX_START:  txd_n = 1'b0;
      TX_DATA:   txd_n = tx_cur[tx_bit_n];
      TX_PARITY: txd_n = ^tx_cur;
      default:   txd_n = 1'b1;
    endcase
  end

  // ----------------------------------------------------------------- receive
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  rx_state_t     rx_state, rx_state_n;
  logic          rx_s1, rx_sync, rx_prev, rx_fall;
  logic [DW-1:0] rx_div, rx_div_n;
  logic [TW-1:0] rx_tick, rx_tick_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic          rx_byte, rx_byte_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic [7:0]    rx_low, rx_low_n;
  logic          rx_par, rx_par_n;
  logic [15:0]   data_out_n;
  logic          rx_valid_n, rx_error_n;
  logic          rx_tick_en, rx_mid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_div   <= '0;
      rx_tick  <= '0;
      rx_bit   <= '0;
      rx_byte  <= 1'b0;
      rx_shift <= '0;
      rx_low   <= '0;
      rx_par   <= 1'b0;
      data_out <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_s1    <= RxD;
      rx_sync  <= rx_s1;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_n;
      rx_div   <= rx_div_n;
      rx_tick  <= rx_tick_n;
      rx_bit   <= rx_bit_n;
      rx_byte  <= rx_byte_n;
      rx_shift <= rx_shift_n;
      rx_low   <= rx_low_n;
      rx_par   <= rx_par_n;
      data_out <= data_out_n;
      rx_valid <= rx_valid_n;
      rx_error <= rx_error_n;
    end
  end

  always_comb begin
    rx_fall    = rx_prev & ~rx_sync;
    rx_tick_en = (rx_div == div_last);
    rx_mid     = rx_tick_en && (rx_tick == TICK_LAST);
    rx_state_n = rx_state;
    rx_div_n   = rx_tick_en ? '0 : rx_div + 1'b1;
    rx_tick_n  = rx_tick_en ? rx_tick + 1'b1 : rx_tick;
    rx_bit_n   = rx_bit;
    rx_byte_n  = rx_byte;
    rx_shift_n = rx_shift;
    rx_low_n   = rx_low;
    rx_par_n   = rx_par;
    data_out_n = data_out;
    rx_valid_n = 1'b0;
    rx_error_n = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_div_n  = '0;
        rx_tick_n = '0;
        if (rx_fall) rx_state_n = RX_START;
      end
      // Half a bit after the falling edge; later samples land one full bit apart
      RX_START: if (rx_tick_en && rx_tick == TICK_HALF) begin
        rx_tick_n = '0;
        if (rx_sync) rx_state_n = RX_IDLE;
        else begin
          rx_state_n = RX_DATA;
          rx_bit_n   = '0;
        end
      end
      RX_DATA: if (rx_mid) begin
        rx_shift_n = {rx_sync, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_n = RX_PARITY;
        else                rx_bit_n   = rx_bit + 1'b1;
      end
      RX_PARITY: if (rx_mid) begin
        rx_par_n   = rx_sync;
        rx_state_n = RX_STOP;
      end
      RX_STOP: if (rx_mid) begin
        rx_state_n = RX_IDLE;
        if ((rx_par != ^rx_shift) || !rx_sync) begin
          rx_error_n = 1'b1;
          rx_byte_n  = 1'b0;
        end else if (!rx_byte) begin
          rx_low_n  = rx_shift;
          rx_byte_n = 1'b1;
        end else begin
          data_out_n = {rx_shift, rx_low};
          rx_valid_n = 1'b1;
          rx_byte_n  = 1'b0;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
    if (!RX_EN) begin
      rx_state_n = RX_IDLE;
      rx_byte_n  = 1'b0;
      rx_div_n   = '0;
      rx_tick_n  = '0;
      data_out_n = data_out;
      rx_valid_n = 1'b0;
      rx_error_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_channel_link.sv
// Bench for uart_channel_link: TX line frames checked against an 8E1 frame model,
// RX checked through loopback and bench-driven (corrupted) frames.
module tb_uart_channel_link;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  baud_select;
  logic [15:0] data_in;
  logic        transfer_data;
  logic        RX_EN;
  logic        RxD;
  logic        TxD;
  logic        tx_busy;
  logic [15:0] data_out;
  logic        rx_valid;
  logic        rx_error;

  logic        loop_en;
  logic        rxd_drv;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  int last_valid_cyc = 0;
  logic [15:0] exp_data;

  uart_channel_link #(.CLK_FREQ_HZ(50000000), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .data_in(data_in),
    .transfer_data(transfer_data), .RX_EN(RX_EN), .RxD(RxD), .TxD(TxD),
    .tx_busy(tx_busy), .data_out(data_out), .rx_valid(rx_valid), .rx_error(rx_error)
  );

  always #10 clk = ~clk;
  assign RxD = loop_en ? TxD : rxd_drv;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (rx_valid === 1'b1) begin
        vcnt = vcnt + 1;
        last_valid_cyc = cyc;
      end
      if (rx_error === 1'b1) ecnt = ecnt + 1;
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // Clocks per bit from the nominal baud table at 50 MHz, 16x oversampling.
  function automatic int bit_clks(input int sel);
    int bauds [8];
    int baud;
    bauds = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
    baud = bauds[sel];
    return 16 * ((50000000 + 8 * baud) / (16 * baud));
  endfunction

  // Line bits of one frame in time order: start, d0..d7, even parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = ((ones % 2) == 1);
    f[10]  = 1'b1;
    return f;
  endfunction

  function automatic logic [21:0] line_of(input logic [15:0] w);
    return {frame_of(w[15:8]), frame_of(w[7:0])};
  endfunction

  task automatic request(input logic [15:0] w);
    @(negedge clk);
    data_in = w;
    transfer_data = 1'b0;
    repeat (3) @(negedge clk);
    transfer_data = 1'b1;
  endtask

  task automatic capture_word(input int bitclk, output logic [21:0] bits,
                              output int start_len, output int fall_cyc, output bit found);
    bit sawhigh;
    logic [4:0] bi;
    found = 1'b0;
    bits = '0;
    start_len = 0;
    fall_cyc = 0;
    sawhigh = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (TxD === 1'b0) found = 1'b1;
    end
    if (found) begin
      fall_cyc = cyc;
      for (int k = 0; k < 22 * bitclk; k++) begin
        if (k > 0) @(negedge clk);
        if (!sawhigh && TxD === 1'b0) start_len++;
        else sawhigh = 1'b1;
        if ((k % bitclk) == bitclk / 2) begin
          bi = 5'(k / bitclk);
          bits[bi] = TxD;
        end
      end
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int bitclk, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = frame_of(b);
    if (bad_par) f[9] = ~f[9];
    if (bad_stop) f[10] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      rxd_drv = f[i];
      repeat (bitclk) @(negedge clk);
    end
  endtask

  task automatic check_frames(input string name, input bit found,
                              input logic [21:0] bits, input logic [15:0] w);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: TxD never fell within 200 clocks", name);
    end else if (bits !== line_of(w)) begin
      errors++;
      $display("FAIL %s: line bits got %b expected %b", name, bits, line_of(w));
    end
  endtask

  task automatic check_idle_line(input string name, input int n);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: TxD/tx_busy activity got TxD=%b busy=%b expected idle", name, TxD, tx_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    baud_select = 3'd5;
    data_in = '0;
    transfer_data = 1'b0;
    RX_EN = 1'b1;
    loop_en = 1'b1;
    rxd_drv = 1'b1;
    exp_data = '0;
    repeat (5) @(negedge clk);
    checks++; if (TxD !== 1'b1)      begin errors++; $display("FAIL reset_txd: got %b expected 1", TxD); end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL reset_rx_error: got %b expected 0", rx_error); end
    reset = 1'b1;
    check_idle_line("post_reset_idle", 50);
    checks++;
    if (vcnt != 0 || ecnt != 0) begin
      errors++;
      $display("FAIL post_reset_pulses: got valid=%0d error=%0d expected 0 0", vcnt, ecnt);
    end
  endtask

  task automatic test_loopback_basic();
    int bc, slen, fcyc, v0, lat, exp_lat;
    logic [21:0] bits;
    bit found, ok;
    baud_select = 3'd5;
    bc = bit_clks(5);
    v0 = vcnt;
    request(16'h3333);
    fork
      capture_word(bc, bits, slen, fcyc, found);
      begin
        repeat (3) @(negedge clk);
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b expected 1", tx_busy); end
        repeat (47) @(negedge clk);
        data_in = 16'h0005;
      end
    join
    check_frames("frames_3333", found, bits, 16'h3333);
    wait_idle(5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_fall: tx_busy got %b expected 0 at word end", tx_busy); end
    repeat (10) @(negedge clk);
    exp_data = 16'h3333;
    checks++;
    if (vcnt != v0 + 1) begin errors++; $display("FAIL rx_valid_count_3333: got %0d expected 1", vcnt - v0); end
    checks++;
    if (data_out !== exp_data) begin errors++; $display("FAIL data_out_3333: got %h expected %h", data_out, exp_data); end
    lat = last_valid_cyc - fcyc;
    exp_lat = (bc * 43) / 2 + 3;
    checks++;
    if (lat < exp_lat - 3 || lat > exp_lat + 3) begin
      errors++;
      $display("FAIL rx_latency: got %0d clocks expected about %0d", lat, exp_lat);
    end
  endtask

  task automatic test_second_word();
    int bc, slen, fcyc, v0;
    logic [21:0] bits;
    bit found, ok;
    baud_select = 3'd7;
    bc = bit_clks(7);
    v0 = vcnt;
    request(16'h0005);
    capture_word(bc, bits, slen, fcyc, found);
    check_frames("frames_0005", found, bits, 16'h0005);
    wait_idle(5, ok);
    repeat (10) @(negedge clk);
    exp_data = 16'h0005;
    checks++;
    if (!ok || vcnt != v0 + 1) begin errors++; $display("FAIL rx_valid_count_0005: got %0d busy_ok=%b expected 1", vcnt - v0, ok); end
    checks++;
    if (data_out !== exp_data) begin errors++; $display("FAIL data_out_0005: got %h expected %h", data_out, exp_data); end
    check_idle_line("held_high_no_retrigger", 3 * bc);
  endtask

  task automatic test_parity_error();
    int bc, v0, e0;
    bc = bit_clks(7);
    rxd_drv = 1'b1;
    loop_en = 1'b0;
    repeat (20) @(negedge clk);
    v0 = vcnt;
    e0 = ecnt;
    send_frame(8'hC3, bc, 1'b0, 1'b0);
    send_frame(8'hA5, bc, 1'b1, 1'b0);
    rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (ecnt != e0 + 1) begin errors++; $display("FAIL parity_rx_error: got %0d pulses expected 1", ecnt - e0); end
    checks++;
    if (vcnt != v0) begin errors++; $display("FAIL parity_no_valid: got %0d pulses expected 0", vcnt - v0); end
    checks++;
    if (data_out !== exp_data) begin errors++; $display("FAIL parity_data_out: got %h expected %h", data_out, exp_data); end
  endtask

  task automatic test_stop_error();
    int bc, v0, e0, slen, fcyc;
    logic [21:0] bits;
    bit found, ok;
    bc = bit_clks(7);
    v0 = vcnt;
    e0 = ecnt;
    send_frame(8'($urandom), bc, 1'b0, 1'b1);
    rxd_drv = 1'b1;
    repeat (2 * bc + $urandom_range(0, 50)) @(negedge clk);
    checks++;
    if (ecnt != e0 + 1 || vcnt != v0) begin
      errors++;
      $display("FAIL stop_rx_error: got err=%0d valid=%0d expected 1 0", ecnt - e0, vcnt - v0);
    end
    loop_en = 1'b1;
    request(16'h1234);
    capture_word(bc, bits, slen, fcyc, found);
    check_frames("frames_1234", found, bits, 16'h1234);
    wait_idle(5, ok);
    repeat (10) @(negedge clk);
    exp_data = 16'h1234;
    checks++;
    if (!ok || vcnt != v0 + 1) begin errors++; $display("FAIL rx_valid_count_1234: got %0d busy_ok=%b expected 1", vcnt - v0, ok); end
    checks++;
    if (data_out !== exp_data) begin errors++; $display("FAIL data_out_1234: got %h expected %h", data_out, exp_data); end
  endtask

  task automatic test_busy_retrigger();
    int bc, slen, fcyc, v0;
    logic [21:0] bits;
    logic [15:0] w;
    bit found, ok;
    bc = bit_clks(7);
    w = 16'($urandom) | 16'h0001;
    v0 = vcnt;
    request(w);
    fork
      capture_word(bc, bits, slen, fcyc, found);
      begin
        repeat (2000) @(negedge clk);
        transfer_data = 1'b0;
        repeat (4) @(negedge clk);
        data_in = ~w;
        transfer_data = 1'b1;
      end
    join
    checks++;
    if (slen != bc) begin errors++; $display("FAIL bit_width_b7: got %0d clocks expected %0d", slen, bc); end
    check_frames("frames_random", found, bits, w);
    wait_idle(5, ok);
    repeat (10) @(negedge clk);
    exp_data = w;
    checks++;
    if (!ok || vcnt != v0 + 1 || data_out !== exp_data) begin
      errors++;
      $display("FAIL data_out_random: got %h (valid %0d) expected %h", data_out, vcnt - v0, exp_data);
    end
    check_idle_line("busy_edge_ignored", 3 * bc);
  endtask

  task automatic test_rx_disable();
    int bc, slen, fcyc, v0, e0;
    logic [21:0] bits;
    logic [15:0] w;
    bit found, ok;
    bc = bit_clks(7);
    w = 16'($urandom);
    v0 = vcnt;
    e0 = ecnt;
    request(w);
    fork
      capture_word(bc, bits, slen, fcyc, found);
      begin
        repeat (3 * bc) @(negedge clk);
        RX_EN = 1'b0;
      end
    join
    check_frames("frames_rx_disabled", found, bits, w);
    wait_idle(5, ok);
    repeat (2 * bc) @(negedge clk);
    RX_EN = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (vcnt != v0 || ecnt != e0) begin
      errors++;
      $display("FAIL rx_disabled_pulses: got valid=%0d error=%0d expected 0 0", vcnt - v0, ecnt - e0);
    end
    checks++;
    if (data_out !== exp_data) begin errors++; $display("FAIL rx_disabled_data_out: got %h expected %h", data_out, exp_data); end
  endtask

  initial begin
    test_reset();
    test_loopback_basic();
    test_second_word();
    test_parity_error();
    test_stop_error();
    test_busy_retrigger();
    test_rx_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
